// File: rtl/spgd_pkg.sv
// Shared constants and types for the SPGD settle/acquisition responder.
package spgd_pkg;

   localparam int ADC_W  = 14;  // signed ADC sample width
   localparam int CNT_W  = 16;  // DAC settle count width
   localparam int MAX_L2 = 15;  // largest log2 averaging length
   localparam int ACC_W  = ADC_W + MAX_L2;  // sum of 2^MAX_L2 samples never overflows

   // Per-channel state shared by both counters
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ch_state_e;

   // Bit positions of the control word driven by the sequencer FSM
   localparam int CTL_DAC_START = 0;
   localparam int CTL_DAC_RST   = 1;
   localparam int CTL_ADC_START = 2;
   localparam int CTL_ADC_RST   = 3;
   localparam int CTL_W         = 4;

endpackage

// File: rtl/spgd_trig_counter.sv
// Start/clear/threshold counter with a held trigger.
// IDLE latches the threshold on start; RUN counts start-high cycles and
// fires on the cycle the count equals the threshold; DONE holds the trigger
// until clr. clr always wins over start.
module spgd_trig_counter
   import spgd_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic         clr,
   input  logic [W-1:0] thr,
   output logic         trig,   // registered, held until clr
   output logic         load,   // IDLE->RUN this edge
   output logic         step,   // RUN with start this edge (a counted cycle)
   output logic         fire    // completion this edge
);

   ch_state_e    state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] thr_q, thr_d;
   logic         trig_q, trig_d;

   // Next-state: clr > start > hold
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      thr_d   = thr_q;
      trig_d  = trig_q;
      load    = 1'b0;
      step    = 1'b0;
      fire    = 1'b0;
      if (clr) begin
         state_d = IDLE;
         cnt_d   = '0;
         trig_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               load    = 1'b1;
               thr_d   = thr;
               cnt_d   = '0;
               state_d = RUN;
            end
            RUN: if (start) begin
               step = 1'b1;
               if (cnt_q == thr_q) begin
                  fire    = 1'b1;
                  trig_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         thr_q   <= '0;
         trig_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         thr_q   <= thr_d;
         trig_q  <= trig_d;
      end
   end

   assign trig = trig_q;

endmodule

// File: rtl/spgd_settle_acq.sv
// DAC-settle timer and ADC averaging acquisition for the SPGD sequencer.
// Two independent trig counters; the ADC side adds an accumulator and an
// arithmetic-shift average that updates j_value with a one-cycle j_valid.
module spgd_settle_acq
   import spgd_pkg::*;
(
   input  logic             adc_clk,
   input  logic             adc_rstn,
   input  logic             dac_cnt_start,
   input  logic             dac_cnt_rst,
   input  logic             adc_cnt_start,
   input  logic             adc_cnt_rst,
   input  logic [CNT_W-1:0] dac_settle,
   input  logic [3:0]       avg_l2,
   input  logic [ADC_W-1:0] adc_dat,
   output logic             dac_cnt_trig,
   output logic             adc_cnt_trig,
   output logic [ADC_W-1:0] j_value,
   output logic             j_valid
);

   logic dac_load_unused, dac_step_unused, dac_fire_unused;
   logic adc_load, adc_step, adc_fire;

   logic [3:0]              l_eff;
   logic [CNT_W-1:0]        adc_thr;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] sum, avg;
   logic [3:0]              l_q, l_d;
   logic [ADC_W-1:0]        j_value_q, j_value_d;
   logic                    j_valid_q, j_valid_d;

   spgd_trig_counter #(.W(CNT_W)) u_dac (
      .clk   (adc_clk),
      .rstn  (adc_rstn),
      .start (dac_cnt_start),
      .clr   (dac_cnt_rst),
      .thr   (dac_settle),
      .trig  (dac_cnt_trig),
      .load  (dac_load_unused),
      .step  (dac_step_unused),
      .fire  (dac_fire_unused)
   );

   // Clamp the averaging length; the ADC counter fires on sample 2^L
   assign l_eff   = (avg_l2 > 4'(MAX_L2)) ? 4'(MAX_L2) : avg_l2;
   assign adc_thr = CNT_W'((32'd1 << l_eff) - 32'd1);

   spgd_trig_counter #(.W(CNT_W)) u_adc (
      .clk   (adc_clk),
      .rstn  (adc_rstn),
      .start (adc_cnt_start),
      .clr   (adc_cnt_rst),
      .thr   (adc_thr),
      .trig  (adc_cnt_trig),
      .load  (adc_load),
      .step  (adc_step),
      .fire  (adc_fire)
   );

   // Final sample is folded in on the completion edge, so average the sum
   assign sum = acc_q + {{MAX_L2{adc_dat[ADC_W-1]}}, adc_dat};
   assign avg = sum >>> l_q;

   // Accumulate / average; abort clears the sum but keeps j_value
   always_comb begin
      acc_d     = acc_q;
      l_d       = l_q;
      j_value_d = j_value_q;
      j_valid_d = 1'b0;
      if (adc_cnt_rst) begin
         acc_d = '0;
      end else if (adc_load) begin
         acc_d = '0;
         l_d   = l_eff;
      end else if (adc_step) begin
         acc_d = sum;
         if (adc_fire) begin
            j_value_d = avg[ADC_W-1:0];
            j_valid_d = 1'b1;
         end
      end
   end

   // Accumulator and output registers
   always_ff @(posedge adc_clk or negedge adc_rstn) begin
      if (!adc_rstn) begin
         acc_q     <= '0;
         l_q       <= '0;
         j_value_q <= '0;
         j_valid_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         l_q       <= l_d;
         j_value_q <= j_value_d;
         j_valid_q <= j_valid_d;
      end
   end

   assign j_value = j_value_q;
   assign j_valid = j_valid_q;

endmodule

// File: tb/tb_spgd_settle_acq.sv
// Self-checking bench for spgd_settle_acq: a behavioural model (sample queue,
// remaining-cycle countdown) compared every cycle, plus literal checks.
module tb_spgd_settle_acq;
   import spgd_pkg::*;

   logic             adc_clk = 1'b0;
   logic             adc_rstn = 1'b0;
   logic             dac_cnt_start = 1'b0, dac_cnt_rst = 1'b0;
   logic             adc_cnt_start = 1'b0, adc_cnt_rst = 1'b0;
   logic [CNT_W-1:0] dac_settle = '0;
   logic [3:0]       avg_l2 = '0;
   logic [ADC_W-1:0] adc_dat = '0;
   logic             dac_cnt_trig, adc_cnt_trig, j_valid;
   logic [ADC_W-1:0] j_value;

   int tests = 0;
   int errs  = 0;
   int jv_cnt = 0;

   spgd_settle_acq dut (
      .adc_clk       (adc_clk),
      .adc_rstn      (adc_rstn),
      .dac_cnt_start (dac_cnt_start),
      .dac_cnt_rst   (dac_cnt_rst),
      .adc_cnt_start (adc_cnt_start),
      .adc_cnt_rst   (adc_cnt_rst),
      .dac_settle    (dac_settle),
      .avg_l2        (avg_l2),
      .adc_dat       (adc_dat),
      .dac_cnt_trig  (dac_cnt_trig),
      .adc_cnt_trig  (adc_cnt_trig),
      .j_value       (j_value),
      .j_valid       (j_valid)
   );

   always #5 adc_clk = ~adc_clk;

   // ---------------- behavioural model ----------------
   bit  m_dac_act, m_dac_trig;
   int  m_dac_need;
   bit  m_adc_act, m_adc_trig, m_jvalid;
   int  m_L, m_j;
   int  samp[$];

   function automatic int floor_div(input longint s, input longint d);
      longint q;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      return int'(q);
   endfunction

   always @(posedge adc_clk or negedge adc_rstn) begin
      longint s;
      if (!adc_rstn) begin
         m_dac_act = 0; m_dac_trig = 0; m_dac_need = 0;
         m_adc_act = 0; m_adc_trig = 0; m_jvalid = 0; m_L = 0; m_j = 0;
         samp.delete();
      end else begin
         m_jvalid = 0;
         // DAC: trigger after N+1 start-high cycles once running
         if (dac_cnt_rst) begin
            m_dac_act = 0; m_dac_trig = 0;
         end else if (dac_cnt_start && !m_dac_trig) begin
            if (!m_dac_act) begin
               m_dac_act = 1; m_dac_need = int'(dac_settle) + 1;
            end else begin
               m_dac_need--;
               if (m_dac_need == 0) m_dac_trig = 1;
            end
         end
         // ADC: collect 2^L samples, floor-average them
         if (adc_cnt_rst) begin
            m_adc_act = 0; m_adc_trig = 0; samp.delete();
         end else if (adc_cnt_start && !m_adc_trig) begin
            if (!m_adc_act) begin
               m_adc_act = 1; m_L = (int'(avg_l2) > MAX_L2) ? MAX_L2 : int'(avg_l2);
               samp.delete();
            end else begin
               samp.push_back(int'($signed(adc_dat)));
               if (samp.size() == (1 << m_L)) begin
                  s = 0;
                  foreach (samp[i]) s += samp[i];
                  m_j = floor_div(s, longint'(1) << m_L);
                  m_jvalid = 1; m_adc_trig = 1;
               end
            end
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge
   always @(negedge adc_clk) begin
      if (adc_rstn) begin
         tests++;
         if (dac_cnt_trig !== m_dac_trig || adc_cnt_trig !== m_adc_trig ||
             j_valid !== m_jvalid || int'($signed(j_value)) != m_j) begin
            errs++;
            $display("FAIL model t=%0t dac_trig %b/%b adc_trig %b/%b j_valid %b/%b j_value %0d/%0d (got/exp)",
                     $time, dac_cnt_trig, m_dac_trig, adc_cnt_trig, m_adc_trig,
                     j_valid, m_jvalid, $signed(j_value), m_j);
         end
         if (j_valid) jv_cnt++;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge adc_clk);
      #1;
   endtask

   task automatic dac_wait(output int n);
      n = 0;
      while (!dac_cnt_trig && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic dac_clear();
      dac_cnt_start = 0; dac_cnt_rst = 1; tick(); dac_cnt_rst = 0;
   endtask

   task automatic adc_clear();
      adc_cnt_start = 0; adc_cnt_rst = 1; tick(); adc_cnt_rst = 0;
   endtask

   // Start an acquisition and feed 2^l2 samples base, base+step, ...
   task automatic adc_acq(input int l2, input int base, input int step);
      avg_l2 = 4'(l2); adc_cnt_start = 1; adc_dat = '0;
      tick();
      for (int i = 0; i < (1 << l2); i++) begin
         adc_dat = ADC_W'(base + i * step);
         tick();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int jv0;

      tick(); tick();
      chk("rst_dac_trig", int'(dac_cnt_trig), 0);
      chk("rst_adc_trig", int'(adc_cnt_trig), 0);
      chk("rst_j_value", int'(j_value), 0);
      chk("rst_j_valid", int'(j_valid), 0);
      adc_rstn = 1;
      tick();

      // DAC N=10: trigger 12 cycles after start, held with start low
      dac_settle = 16'd10; dac_cnt_start = 1;
      dac_wait(n);
      chk("dac_lat_n10", n, 12);
      dac_cnt_start = 0; tick(); tick(); tick();
      chk("dac_hold", int'(dac_cnt_trig), 1);
      dac_cnt_rst = 1; tick();
      chk("dac_clr", int'(dac_cnt_trig), 0);
      dac_cnt_rst = 0; tick();

      // DAC N=0
      dac_settle = 16'd0; dac_cnt_start = 1;
      dac_wait(n);
      chk("dac_lat_n0", n, 2);
      dac_clear();

      // DAC pause of 3 cycles, plus a settle change after latching
      dac_settle = 16'd10; dac_cnt_start = 1;
      n = 0;
      repeat (4) begin tick(); n++; end
      dac_settle = 16'd2; dac_cnt_start = 0;
      repeat (3) begin tick(); n++; end
      dac_cnt_start = 1;
      while (!dac_cnt_trig && n < 200) begin tick(); n++; end
      chk("dac_lat_pause", n, 15);
      dac_clear();

      // start and rst together: never triggers
      dac_settle = 16'd0; dac_cnt_start = 1; dac_cnt_rst = 1;
      n = 0;
      repeat (10) begin tick(); if (dac_cnt_trig) n++; end
      chk("dac_rst_wins", n, 0);
      dac_cnt_start = 0; dac_cnt_rst = 0; tick();

      // ADC ramp -8..-1, L=3 -> floor(-36/8) = -5
      adc_acq(3, -8, 1);
      chk("adc_ramp_j", int'($signed(j_value)), -5);
      chk("adc_ramp_valid", int'(j_valid), 1);
      chk("adc_ramp_trig", int'(adc_cnt_trig), 1);
      adc_cnt_start = 0; tick();
      chk("adc_valid_pulse", int'(j_valid), 0);
      chk("adc_trig_held", int'(adc_cnt_trig), 1);
      adc_clear();
      chk("adc_clr_keep_j", int'($signed(j_value)), -5);

      // Extremes at L=15
      adc_acq(15, 8191, 0);
      chk("adc_max_pos", int'($signed(j_value)), 8191);
      adc_clear();
      adc_acq(15, -8192, 0);
      chk("adc_max_neg", int'($signed(j_value)), -8192);
      adc_clear();

      // L=0 stores the sample; trigger 2 cycles after start
      adc_acq(0, -77, 0);
      chk("adc_l0_j", int'($signed(j_value)), -77);
      adc_clear();
      adc_acq(0, 1234, 0);
      chk("adc_l0_j2", int'($signed(j_value)), 1234);
      adc_clear();

      // Abort at sample 5 of 8
      jv0 = jv_cnt;
      avg_l2 = 4'd3; adc_cnt_start = 1; tick();
      for (int i = 0; i < 4; i++) begin adc_dat = ADC_W'(i * 100); tick(); end
      adc_dat = 14'd500; adc_cnt_rst = 1; tick();
      adc_cnt_rst = 0; adc_cnt_start = 0; tick();
      chk("abort_no_valid", jv_cnt - jv0, 0);
      chk("abort_keep_j", int'($signed(j_value)), 1234);
      // Follow-up run: 100,103..121 -> 884/8 -> 110
      adc_acq(3, 100, 3);
      chk("after_abort_j", int'($signed(j_value)), 110);

      // Async reset mid-run: everything zero immediately
      dac_settle = 16'd50; dac_cnt_start = 1;
      tick(); tick(); tick();
      adc_rstn = 0; #2;
      chk("arst_dac_trig", int'(dac_cnt_trig), 0);
      chk("arst_adc_trig", int'(adc_cnt_trig), 0);
      chk("arst_j_value", int'(j_value), 0);
      chk("arst_j_valid", int'(j_valid), 0);
      dac_cnt_start = 0; adc_cnt_start = 0;
      tick(); adc_rstn = 1; tick();
      dac_settle = 16'd0; dac_cnt_start = 1;
      dac_wait(n);
      chk("arst_idle_dac", n, 2);
      dac_clear();

      // FSM-style sequence: settle, J+, settle, J-
      jv0 = jv_cnt;
      dac_settle = 16'd5; dac_cnt_start = 1;
      dac_wait(n);
      chk("seq_settle1", n, 7);
      dac_clear();
      adc_acq(2, 10, 11);            // 10,21,32,43 -> 106/4 -> 26
      chk("seq_jplus", int'($signed(j_value)), 26);
      adc_clear();
      dac_cnt_start = 1;
      dac_wait(n);
      chk("seq_settle2", n, 7);
      dac_clear();
      adc_acq(2, -10, -11);          // -106/4 -> floor -27
      chk("seq_jminus", int'($signed(j_value)), -27);
      adc_clear();
      tick();
      chk("seq_two_pulses", jv_cnt - jv0, 2);

      // Randomized traffic on both channels, checked by the model
      for (int c = 0; c < 3000; c++) begin
         dac_cnt_start = ($urandom_range(0, 3) != 0);
         dac_cnt_rst   = ($urandom_range(0, 24) == 0);
         adc_cnt_start = ($urandom_range(0, 3) != 0);
         adc_cnt_rst   = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 9) == 0) dac_settle = CNT_W'($urandom_range(0, 30));
         if ($urandom_range(0, 9) == 0) avg_l2 = 4'($urandom_range(0, 5));
         adc_dat = ADC_W'($urandom);
         tick();
      end
      dac_cnt_start = 0; adc_cnt_start = 0; dac_cnt_rst = 0; adc_cnt_rst = 0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
